// File: rtl/fp32_div_retire.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_div_retire
//  Purpose  : Retire stage behind the combinational fp32 divider. Each divider
//             result (y + IEEE-754 exception bits) and its issue tag goes into
//             a small valid/ready FIFO. Results leave the FIFO in order. The
//             exception bits of every retired entry are OR-ed into a sticky
//             fflags register.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TAG_W         width of the opaque tag carried with each result
//    DEPTH         FIFO entries (power of two, >= 2)
//  Ports
//    clk, rst_n    clock (rising edge), asynchronous active-low reset
//    in_valid/in_ready, in_tag, in_y, in_exc
//                  producer side handshake and payload
//                  (in_exc = {invalid, divzero, overflow, underflow, inexact})
//    out_valid/out_ready, out_tag, out_y, out_exc
//                  consumer side handshake and head-entry payload
//    flush         synchronous discard of all queued entries
//    fflags_wr, fflags_wdata, fflags_clr
//                  software write / clear of the sticky flag register
//    fflags        sticky accumulated exception flags
//    count         current FIFO occupancy
//  Configuration macro
//    FP32_DIV_RETIRE_CANON_NAN_EN
//                  when defined, any NaN result is stored as the canonical
//                  quiet NaN 32'h7FC00000. The exception bits are unchanged.
// ============================================================================
module fp32_div_retire #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // producer side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [31:0]              in_y,
  input  logic [4:0]               in_exc,
  // consumer side
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [31:0]              out_y,
  output logic [4:0]               out_exc,
  // control
  input  logic                     flush,
  input  logic                     fflags_wr,
  input  logic [4:0]               fflags_wdata,
  input  logic                     fflags_clr,
  output logic [4:0]               fflags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_EMPTY = '0;
  localparam logic [31:0]      C_QNAN  = 32'h7FC0_0000;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [31:0]      r_mem_y   [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];
  logic [4:0]       r_mem_exc [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_fflags;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_store_y;
  logic [4:0]       w_fflags_base;
  logic [4:0]       w_fflags_next;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // Both flags come from the registered occupancy only, so there is no
  // combinational path from out_ready to in_ready. When full, a same-cycle pop
  // does not open the input.
  assign in_ready  = (r_count != C_FULL);
  assign out_valid = (r_count != C_EMPTY);

  // A push coinciding with flush is dropped: the entry must never be seen.
  assign w_push = in_valid && in_ready && !flush;
  // A pop during flush still retires normally, including its flags.
  assign w_pop  = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Optional NaN canonicalisation at push time
  // --------------------------------------------------------------------------
`ifdef FP32_DIV_RETIRE_CANON_NAN_EN
  always_comb begin
    w_store_y = in_y;
    if ((in_y[30:23] == 8'hFF) && (in_y[22:0] != 23'd0)) begin
      w_store_y = C_QNAN;
    end
  end
`else
  // Bit-exact storage; the canonical NaN constant is unused in this build.
  assign w_store_y = in_y;
  logic w_unused_qnan;
  assign w_unused_qnan = ^C_QNAN;
`endif

  // --------------------------------------------------------------------------
  // Head-entry outputs
  // --------------------------------------------------------------------------
  // The outputs read the storage at the registered read pointer. They only
  // move when the read pointer moves or the head slot is written. Neither
  // happens while the head is held (valid && !ready): a push never targets the
  // occupied head slot.
  assign out_tag = r_mem_tag[r_rd_ptr];
  assign out_y   = r_mem_y[r_rd_ptr];
  assign out_exc = r_mem_exc[r_rd_ptr];

  assign count   = r_count;
  assign fflags  = r_fflags;

  // --------------------------------------------------------------------------
  // Sticky flag next-state
  // --------------------------------------------------------------------------
  // A write has priority over a clear. The retiring entry's bits are OR-ed in
  // after either, so a retire in the same cycle as a write/clear is kept.
  always_comb begin
    w_fflags_base = r_fflags;
    if (fflags_wr) begin
      w_fflags_base = fflags_wdata;
    end else if (fflags_clr) begin
      w_fflags_base = 5'b0;
    end
    w_fflags_next = w_fflags_base | (w_pop ? out_exc : 5'b0);
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_y[i]   <= '0;
        r_mem_tag[i] <= '0;
        r_mem_exc[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_fflags <= '0;
    end else begin
      if (w_push) begin
        r_mem_y[r_wr_ptr]   <= w_store_y;
        r_mem_tag[r_wr_ptr] <= in_tag;
        r_mem_exc[r_wr_ptr] <= in_exc;
      end

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        // DEPTH is a power of two, so natural pointer overflow wraps
        // modulo DEPTH.
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end

      r_fflags <= w_fflags_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_retire.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp32_div_retire
//  Purpose  : Self-checking bench for fp32_div_retire. It applies a table of
//             hand-computed cycle vectors, then short directed sequences (NaN
//             storage, asynchronous reset). It finishes with randomized
//             traffic checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_div_retire;

  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      in_y = '0;
  logic [4:0]       in_exc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_y;
  logic [4:0]       out_exc;
  logic             flush = 1'b0;
  logic             fflags_wr = 1'b0;
  logic [4:0]       fflags_wdata = '0;
  logic             fflags_clr = 1'b0;
  logic [4:0]       fflags;
  logic [CNT_W-1:0] count;

  fp32_div_retire #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_y(in_y), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_y(out_y), .out_exc(out_exc),
    .flush(flush), .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata),
    .fflags_clr(fflags_clr), .fflags(fflags), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs are changed, and outputs sampled, 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] canon(input logic [31:0] y);
`ifdef FP32_DIV_RETIRE_CANON_NAN_EN
    if (y[30:23] == 8'hFF && y[22:0] != 0) return 32'h7FC00000;
`endif
    return y;
  endfunction

  // One cycle: inputs applied this cycle, plus the state expected at its start.
  typedef struct {
    logic             iv;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic [4:0]       exc;
    logic             ordy;
    logic             fl;
    logic             wr;
    logic             clr;
    logic [4:0]       wd;
    int               e_cnt;
    logic [TAG_W-1:0] e_tag;
    logic [31:0]      e_y;
    logic [4:0]       e_exc;
    logic [4:0]       e_ff;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic [TAG_W-1:0] tag, input logic [31:0] y,
    input logic [4:0] exc, input logic ordy, input logic fl, input logic wr,
    input logic clr, input logic [4:0] wd, input int e_cnt,
    input logic [TAG_W-1:0] e_tag, input logic [31:0] e_y,
    input logic [4:0] e_exc, input logic [4:0] e_ff);
    vec_t v;
    v.iv = iv; v.tag = tag; v.y = y; v.exc = exc; v.ordy = ordy; v.fl = fl;
    v.wr = wr; v.clr = clr; v.wd = wd; v.e_cnt = e_cnt; v.e_tag = e_tag;
    v.e_y = e_y; v.e_exc = e_exc; v.e_ff = e_ff;
    return v;
  endfunction

  task automatic check_state(input string pfx, input int e_cnt,
                             input logic [TAG_W-1:0] e_tag, input logic [31:0] e_y,
                             input logic [4:0] e_exc, input logic [4:0] e_ff);
    chk({pfx, ".count"},     64'(count),     64'(e_cnt));
    chk({pfx, ".out_valid"}, 64'(out_valid), 64'(e_cnt != 0));
    chk({pfx, ".in_ready"},  64'(in_ready),  64'(e_cnt != DEPTH));
    chk({pfx, ".fflags"},    64'(fflags),    64'(e_ff));
    if (e_cnt != 0) begin
      chk({pfx, ".out_tag"}, 64'(out_tag), 64'(e_tag));
      chk({pfx, ".out_y"},   64'(out_y),   64'(e_y));
      chk({pfx, ".out_exc"}, 64'(out_exc), 64'(e_exc));
    end
  endtask

  task automatic drive(input logic iv, input logic [TAG_W-1:0] tag,
                       input logic [31:0] y, input logic [4:0] exc,
                       input logic ordy, input logic fl, input logic wr,
                       input logic clr, input logic [4:0] wd);
    in_valid = iv; in_tag = tag; in_y = y; in_exc = exc; out_ready = ordy;
    flush = fl; fflags_wr = wr; fflags_clr = clr; fflags_wdata = wd;
  endtask

  // Reference model for the random phase
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic [4:0]       exc;
  } ent_t;

  initial begin
    vec_t tbl[22];
    ent_t q[$];
    ent_t e;
    logic [4:0] m_ff;

    // iv tag y            exc    ordy fl wr clr wd  | cnt tag y            exc    ff
    tbl[0]  = mk(1, 3, 32'h3F800000, 5'h00, 1, 0, 0, 0, 0, 0, 0, 0,            0,     5'h00);
    tbl[1]  = mk(0, 0, 0,            0,     1, 0, 0, 0, 0, 1, 3, 32'h3F800000, 5'h00, 5'h00);
    tbl[2]  = mk(1, 1, 32'h40000000, 5'h03, 0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h00);
    tbl[3]  = mk(1, 2, 32'h40400000, 5'h08, 0, 0, 0, 0, 0, 1, 1, 32'h40000000, 5'h03, 5'h00);
    tbl[4]  = mk(1, 7, 32'hDEADBEEF, 5'h1F, 0, 0, 0, 0, 0, 2, 1, 32'h40000000, 5'h03, 5'h00);
    tbl[5]  = mk(0, 0, 0,            0,     1, 0, 0, 0, 0, 2, 1, 32'h40000000, 5'h03, 5'h00);
    tbl[6]  = mk(0, 0, 0,            0,     1, 0, 0, 0, 0, 1, 2, 32'h40400000, 5'h08, 5'h03);
    tbl[7]  = mk(1, 4, 32'h40800000, 5'h10, 0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h0B);
    tbl[8]  = mk(0, 0, 0,            0,     1, 0, 0, 1, 0, 1, 4, 32'h40800000, 5'h10, 5'h0B);
    tbl[9]  = mk(1, 4'hA, 32'h3F000000, 5'h04, 0, 0, 0, 0, 0, 0, 0, 0,         0,     5'h10);
    tbl[10] = mk(1, 4'hB, 32'h3E800000, 5'h01, 0, 0, 0, 0, 0, 1, 4'hA, 32'h3F000000, 5'h04, 5'h10);
    tbl[11] = mk(1, 4'hC, 32'h12345678, 5'h1F, 0, 1, 0, 0, 0, 2, 4'hA, 32'h3F000000, 5'h04, 5'h10);
    tbl[12] = mk(0, 0, 0,            0,     0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h10);
    tbl[13] = mk(1, 4'hD, 32'h3F800000, 5'h02, 0, 1, 0, 0, 0, 0, 0, 0,         0,     5'h10);
    tbl[14] = mk(0, 0, 0,            0,     0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h10);
    tbl[15] = mk(0, 0, 0,            0,     0, 0, 1, 1, 5'h04, 0, 0, 0,        0,     5'h10);
    tbl[16] = mk(1, 5, 32'h00000001, 5'h00, 1, 0, 0, 0, 0, 0, 0, 0,            0,     5'h04);
    tbl[17] = mk(1, 6, 32'h00000002, 5'h01, 1, 0, 0, 0, 0, 1, 5, 32'h00000001, 5'h00, 5'h04);
    tbl[18] = mk(0, 0, 0,            0,     1, 0, 1, 0, 5'h08, 1, 6, 32'h00000002, 5'h01, 5'h04);
    tbl[19] = mk(1, 8, 32'h00000003, 5'h02, 0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h09);
    tbl[20] = mk(0, 0, 0,            0,     1, 1, 0, 0, 0, 1, 8, 32'h00000003, 5'h02, 5'h09);
    tbl[21] = mk(0, 0, 0,            0,     0, 0, 0, 0, 0, 0, 0, 0,            0,     5'h0B);

    // ---------------- reset ----------------
    #12;
    check_state("reset", 0, 0, 0, 0, 5'h00);
    chk("reset.out_y",   64'(out_y),   64'h0);
    chk("reset.out_tag", 64'(out_tag), 64'h0);
    rst_n = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].iv, tbl[i].tag, tbl[i].y, tbl[i].exc, tbl[i].ordy,
            tbl[i].fl, tbl[i].wr, tbl[i].clr, tbl[i].wd);
      check_state($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_tag,
                  tbl[i].e_y, tbl[i].e_exc, tbl[i].e_ff);
      step();
    end

    // ---------------- NaN storage ----------------
    drive(1, 4'h9, 32'h7F800001, 5'h01, 0, 0, 0, 0, 0);
    step();
`ifdef FP32_DIV_RETIRE_CANON_NAN_EN
    check_state("nan", 1, 4'h9, 32'h7FC00000, 5'h01, 5'h0B);
`else
    check_state("nan", 1, 4'h9, 32'h7F800001, 5'h01, 5'h0B);
`endif

    // ---------------- asynchronous reset with 2 queued, fflags=00100 -------
    drive(1, 4'hE, 32'h40A00000, 5'h00, 0, 0, 1, 0, 5'h04);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("prerst.count",  64'(count),  64'd2);
    chk("prerst.fflags", 64'(fflags), 64'h04);
    #2 rst_n = 1'b0;
    #1;  // well before the next rising edge
    check_state("asyncrst", 0, 0, 0, 0, 5'h00);
    chk("asyncrst.out_y",   64'(out_y),   64'h0);
    chk("asyncrst.out_tag", 64'(out_tag), 64'h0);
    chk("asyncrst.out_exc", 64'(out_exc), 64'h0);
    #3 rst_n = 1'b1;
    step();

    // ---------------- randomized traffic vs. reference model ----------------
    q.delete();
    m_ff = 5'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ry;
      logic        push, pop;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        ry[30:23] = 8'hFF;
        if ($urandom_range(0, 3) != 0) ry[0] = 1'b1;
      end
      drive($urandom_range(0, 9) < 7, TAG_W'($urandom), ry, 5'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
            5'($urandom));

      if (q.size() != 0)
        check_state("rand", q.size(), q[0].tag, q[0].y, q[0].exc, m_ff);
      else
        check_state("rand", 0, 0, 0, 0, m_ff);

      push = in_valid && (q.size() != DEPTH) && !flush;
      pop  = (q.size() != 0) && out_ready;
      m_ff = fflags_wr ? fflags_wdata : (fflags_clr ? 5'b0 : m_ff);
      if (pop) begin
        m_ff = m_ff | q[0].exc;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      if (push) begin
        e.tag = in_tag; e.y = canon(in_y); e.exc = in_exc;
        q.push_back(e);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
